// File: rtl/sme_match_core.sv
// Anchored pattern matcher: scans a captured string one candidate position per
// cycle and reports the first position where the pattern core (with '^'/'$'/'.') hits.
module sme_match_core (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [255:0] str_data,
  input  logic [63:0]  pat_data,
  input  logic [5:0]   str_len,
  input  logic [3:0]   pat_len,
  output logic         busy,
  output logic         valid,
  output logic         match,
  output logic [4:0]   match_index
);

  typedef enum logic [1:0] {IDLE, PREP, SCAN, DONE} state_t;

  localparam logic [7:0] CHR_HEAD = 8'h5E;
  localparam logic [7:0] CHR_TAIL = 8'h24;
  localparam logic [7:0] CHR_ANY  = 8'h2E;
  localparam logic [7:0] CHR_SP   = 8'h20;

  state_t      state_q;
  logic [7:0]  str_q [32];
  logic [7:0]  pat_q [8];
  logic [5:0]  str_len_q;
  logic [3:0]  pat_len_q;
  logic        head_q, tail_q;
  logic [7:0]  core_q [8];
  logic [3:0]  core_len_q;
  logic [5:0]  last_p_q;
  logic [5:0]  p_q;

  // Anchor decode, evaluated while in PREP on the captured pattern.
  logic              pat_ok, str_ok;
  logic              head_d, tail_d;
  logic [7:0]        last_char;
  logic signed [7:0] core_len_s;
  logic signed [7:0] n_s;
  logic              reject;
  logic [7:0]        core_d [8];
  logic [3:0]        src_idx;

  always_comb begin
    pat_ok     = (pat_len_q >= 4'd1) && (pat_len_q <= 4'd8);
    str_ok     = (str_len_q >= 6'd1) && (str_len_q <= 6'd32);
    head_d     = pat_ok && (pat_q[0] == CHR_HEAD);
    last_char  = pat_ok ? pat_q[3'(pat_len_q - 4'd1)] : 8'h00;
    tail_d     = pat_ok && (last_char == CHR_TAIL) && ((pat_len_q > 4'd1) || !head_d);
    core_len_s = 8'(pat_len_q) - 8'(head_d) - 8'(tail_d);
    n_s        = 8'(str_len_q) - core_len_s + 8'sd1;
    reject     = !pat_ok || !str_ok || (core_len_s <= 8'sd0) || (n_s <= 8'sd0);
    for (int k = 0; k < 8; k++) begin
      src_idx   = 4'(k) + 4'(head_d);
      core_d[k] = (src_idx < 4'd8) ? pat_q[src_idx[2:0]] : 8'h00;
    end
  end

  // Candidate evaluation for position p_q: all core chars compared in parallel.
  logic       all_match, head_ok, tail_ok, hit;
  logic [6:0] char_idx;
  logic [6:0] end_idx;
  logic [5:0] prev_idx;

  always_comb begin
    all_match = 1'b1;
    for (int k = 0; k < 8; k++) begin
      char_idx = 7'(p_q) + 7'(k);
      if (4'(k) < core_len_q) begin
        if (!((core_q[k] == CHR_ANY) ||
              ((char_idx < 7'(str_len_q)) && (str_q[char_idx[4:0]] == core_q[k]))))
          all_match = 1'b0;
      end
    end
    prev_idx = p_q - 6'd1;
    head_ok  = !head_q || (p_q == 6'd0) || (str_q[prev_idx[4:0]] == CHR_SP);
    end_idx  = 7'(p_q) + 7'(core_len_q);
    tail_ok  = !tail_q || (end_idx == 7'(str_len_q)) ||
               ((end_idx < 7'(str_len_q)) && (str_q[end_idx[4:0]] == CHR_SP));
    hit      = all_match && head_ok && tail_ok;
  end

  // NOTE: data/buffer registers carry no reset; they are only read after being
  // loaded on start acceptance, so resetting them would add cost for nothing.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && start) begin
      for (int i = 0; i < 32; i++) str_q[i] <= str_data[8*i +: 8];
      for (int j = 0; j < 8; j++)  pat_q[j] <= pat_data[8*j +: 8];
      str_len_q <= str_len;
      pat_len_q <= pat_len;
    end
    if (state_q == PREP) begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      core_len_q <= core_len_s[3:0];
      last_p_q   <= str_len_q - 6'(core_len_s[3:0]);
      for (int k = 0; k < 8; k++) core_q[k] <= core_d[k];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      busy        <= 1'b0;
      valid       <= 1'b0;
      match       <= 1'b0;
      match_index <= 5'd0;
      p_q         <= 6'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= PREP;
            busy    <= 1'b1;
          end
        end
        PREP: begin
          p_q <= 6'd0;
          if (reject) begin
            state_q <= DONE;
            busy    <= 1'b0;
            valid   <= 1'b1;
            match   <= 1'b0;
          end else begin
            state_q <= SCAN;
          end
        end
        SCAN: begin
          if (hit) begin
            state_q     <= DONE;
            busy        <= 1'b0;
            valid       <= 1'b1;
            match       <= 1'b1;
            match_index <= p_q[4:0];
          end else if (p_q == last_p_q) begin
            state_q <= DONE;
            busy    <= 1'b0;
            valid   <= 1'b1;
            match   <= 1'b0;
          end else begin
            p_q <= p_q + 6'd1;
          end
        end
        DONE: begin
          // Result strobe lasts one cycle; start seen here is deliberately dropped.
          state_q     <= IDLE;
          valid       <= 1'b0;
          match       <= 1'b0;
          match_index <= 5'd0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
